// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing the L2 cache's single L1-side port between NUM_REQ L1 requesters.
// One command is in flight at a time; the captured L2 response returns only to the granted port.
module l2_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int BLOCK_SIZE = 32,
  parameter int NUM_REQ    = 2,
  parameter int CNT_WIDTH  = 16,
  localparam int BW        = BLOCK_SIZE * DATA_WIDTH,
  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_read,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*BW-1:0]           req_wdata,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            req_hit,
  output logic                            req_valid,
  output logic [BW-1:0]                   req_rdata,
  output logic [ADDR_WIDTH-1:0]           l2_addr,
  output logic [BW-1:0]                   l2_wdata,
  output logic                            l2_read,
  output logic                            l2_write,
  input  logic [BW-1:0]                   l2_rdata,
  input  logic                            l2_ready,
  input  logic                            l2_hit,
  input  logic                            l2_valid,
  output logic                            busy,
  output logic [NUM_REQ*CNT_WIDTH-1:0]    grant_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  state_t                state_q, state_d;
  logic [IDW-1:0]        rr_q;
  logic [IDW-1:0]        id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BW-1:0]         wdata_q;
  logic                  rd_q, wr_q;
  logic [BW-1:0]         rdata_q;
  logic                  hit_q, valid_q;
  logic [CNT_WIDTH-1:0]  cnt_q [NUM_REQ];

  logic [NUM_REQ-1:0]    pending;
  logic [IDW-1:0]        gnt_id;
  logic                  gnt_found;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign pending = req_read | req_write;

  // Search starts one past the last served port so every requester gets a turn.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_id    = '0;
    gnt_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (!gnt_found && pending[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_found) state_d = BUSY;
      BUSY:    if (l2_ready)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q    <= IDW'(NUM_REQ - 1);
      id_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      hit_q   <= 1'b0;
      valid_q <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: if (gnt_found) begin
          id_q          <= gnt_id;
          addr_q        <= req_addr[gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_q       <= req_wdata[gnt_id*BW +: BW];
          wr_q          <= req_write[gnt_id];
          rd_q          <= req_read[gnt_id] & ~req_write[gnt_id];
          cnt_q[gnt_id] <= sat_inc(cnt_q[gnt_id]);
        end
        BUSY: if (l2_ready) begin
          rdata_q <= l2_rdata;
          hit_q   <= l2_hit;
          valid_q <= l2_valid;
        end
        DONE:    rr_q <= id_q;
        default: ;
      endcase
    end
  end

  // Strobes drop in the ready cycle so the L2 never re-samples a finished command.
  assign l2_read   = (state_q == BUSY) & rd_q & ~l2_ready;
  assign l2_write  = (state_q == BUSY) & wr_q & ~l2_ready;
  assign l2_addr   = addr_q;
  assign l2_wdata  = wdata_q;
  assign req_ready = (state_q == DONE) ? (ONE_HOT0 << id_q) : '0;
  assign req_rdata = rdata_q;
  assign req_hit   = hit_q;
  assign req_valid = valid_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) grant_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter: grant order, L2 handshake timing, write priority,
// long misses, counter saturation (narrow counters) and reset in the middle of a transaction.
module tb_l2_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 11;
  localparam int BS = 32;
  localparam int NR = 2;
  localparam int CW = 3;
  localparam int BW = DW * BS;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_read, req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*BW-1:0]  req_wdata;
  logic [NR-1:0]     req_ready;
  logic              req_hit, req_valid;
  logic [BW-1:0]     req_rdata;
  logic [AW-1:0]     l2_addr;
  logic [BW-1:0]     l2_wdata;
  logic              l2_read, l2_write;
  logic [BW-1:0]     l2_rdata;
  logic              l2_ready, l2_hit, l2_valid;
  logic              busy;
  logic [NR*CW-1:0]  grant_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  l2_port_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS), .NUM_REQ(NR), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_read(req_read), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .req_hit(req_hit), .req_valid(req_valid), .req_rdata(req_rdata),
    .l2_addr(l2_addr), .l2_wdata(l2_wdata), .l2_read(l2_read), .l2_write(l2_write),
    .l2_rdata(l2_rdata), .l2_ready(l2_ready), .l2_hit(l2_hit), .l2_valid(l2_valid),
    .busy(busy), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] pat(input logic [31:0] base);
    logic [BW-1:0] p;
    for (int i = 0; i < BS; i++) p[i*DW +: DW] = base + 32'(i);
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_read  = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    l2_ready  = 1'b0;
    l2_hit    = 1'b0;
    l2_valid  = 1'b0;
    l2_rdata  = '0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      step();
      n_checks++;
      if ({busy, req_ready, l2_read, l2_write, req_hit, req_valid} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: got %b required 0", c,
                 {busy, req_ready, l2_read, l2_write, req_hit, req_valid});
      end
    end
    n_checks++;
    if (grant_cnt !== '0) begin
      n_fail++; $display("FAIL reset_cnt: got %h required 0", grant_cnt);
    end
    n_checks++;
    if (req_rdata !== '0 || l2_wdata !== '0 || l2_addr !== '0) begin
      n_fail++; $display("FAIL reset_data: rdata %h wdata %h addr %h required 0",
                         req_rdata[63:0], l2_wdata[63:0], l2_addr);
    end
  endtask

  task automatic test_read_hit();
    logic [BW-1:0] a;
    a = pat(32'hA5A5_0000);
    do_reset();
    req_addr[0 +: AW] = 11'h040;
    req_read = 2'b01;
    step();
    n_checks++;
    if ({busy, l2_read, l2_write} !== 3'b110 || l2_addr !== 11'h040) begin
      n_fail++; $display("FAIL hit_cmd: busy/rd/wr %b addr %h required 110 040",
                         {busy, l2_read, l2_write}, l2_addr);
    end
    n_checks++;
    if (grant_cnt[0 +: CW] !== 3'd1) begin
      n_fail++; $display("FAIL hit_cnt0: got %0d required 1", grant_cnt[0 +: CW]);
    end
    step();
    l2_ready = 1'b1; l2_rdata = a; l2_hit = 1'b1; l2_valid = 1'b1;
    #1;
    n_checks++;
    if (l2_read !== 1'b0 || req_ready !== 2'b00) begin
      n_fail++; $display("FAIL hit_ready_cycle: l2_read %b req_ready %b required 0 00", l2_read, req_ready);
    end
    step();
    l2_ready = 1'b0; l2_rdata = '0; l2_hit = 1'b0; l2_valid = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 2'b01 || req_hit !== 1'b1 || req_valid !== 1'b1) begin
      n_fail++; $display("FAIL hit_done: ready %b hit %b valid %b required 01 1 1", req_ready, req_hit, req_valid);
    end
    n_checks++;
    if (req_rdata !== a) begin
      n_fail++; $display("FAIL hit_rdata: got %h required %h", req_rdata[63:0], a[63:0]);
    end
    req_read = 2'b00;
    step();
    n_checks++;
    if (req_ready !== 2'b00 || busy !== 1'b0 || req_rdata !== a) begin
      n_fail++; $display("FAIL hit_after: ready %b busy %b rdata %h required 00 0 held", req_ready, busy, req_rdata[63:0]);
    end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_rdy;
    logic [AW-1:0] exp_addr;
    int            w;
    do_reset();
    req_addr[0 +: AW]  = 11'h100;
    req_addr[AW +: AW] = 11'h200;
    req_read = 2'b11;
    for (int t = 0; t < 4; t++) begin
      exp_rdy  = (t % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (t % 2 == 0) ? 11'h100 : 11'h200;
      step();
      w = 0;
      while (!busy && w < 8) begin step(); w++; end
      n_checks++;
      if (busy !== 1'b1 || l2_addr !== exp_addr) begin
        n_fail++; $display("FAIL rr_grant %0d: busy %b addr %h required 1 %h", t, busy, l2_addr, exp_addr);
      end
      step();
      l2_ready = 1'b1; l2_hit = 1'b1; l2_valid = 1'b1; l2_rdata = pat(32'h1000 * 32'(t + 1));
      step();
      l2_ready = 1'b0;
      n_checks++;
      if (req_ready !== exp_rdy) begin
        n_fail++; $display("FAIL rr_ready %0d: got %b required %b", t, req_ready, exp_rdy);
      end
      step();
      n_checks++;
      if (req_ready !== 2'b00) begin
        n_fail++; $display("FAIL rr_pulse_width %0d: got %b required 00", t, req_ready);
      end
    end
    n_checks++;
    if (grant_cnt !== {3'd2, 3'd2}) begin
      n_fail++; $display("FAIL rr_cnt: got %h required %h", grant_cnt, {3'd2, 3'd2});
    end
    req_read = 2'b00;
  endtask

  task automatic test_write_priority();
    logic [BW-1:0] b;
    b = pat(32'hB00B_0000);
    do_reset();
    req_addr[AW +: AW] = 11'h7E0;
    req_wdata[BW +: BW] = b;
    req_read  = 2'b10;
    req_write = 2'b10;
    step();
    n_checks++;
    if ({l2_read, l2_write} !== 2'b01 || l2_addr !== 11'h7E0) begin
      n_fail++; $display("FAIL wr_cmd: rd/wr %b addr %h required 01 7e0", {l2_read, l2_write}, l2_addr);
    end
    n_checks++;
    if (l2_wdata !== b) begin
      n_fail++; $display("FAIL wr_wdata: got %h required %h", l2_wdata[63:0], b[63:0]);
    end
    step();
    l2_ready = 1'b1; l2_hit = 1'b1; l2_valid = 1'b1;
    #1;
    n_checks++;
    if ({l2_read, l2_write} !== 2'b00) begin
      n_fail++; $display("FAIL wr_ready_cycle: rd/wr %b required 00", {l2_read, l2_write});
    end
    step();
    l2_ready = 1'b0;
    n_checks++;
    if (req_ready !== 2'b10 || grant_cnt[CW +: CW] !== 3'd1) begin
      n_fail++; $display("FAIL wr_done: ready %b cnt1 %0d required 10 1", req_ready, grant_cnt[CW +: CW]);
    end
    req_read = 2'b00; req_write = 2'b00;
    step();
  endtask

  task automatic test_read_miss();
    logic [BW-1:0] c;
    c = pat(32'hC0DE_0000);
    do_reset();
    req_addr[0 +: AW] = 11'h123;
    req_read = 2'b01;
    step();
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (l2_read !== 1'b1) begin
        n_fail++; $display("FAIL miss_strobe cycle %0d: got %b required 1", i, l2_read);
      end
      if (i == 5) req_read = 2'b00;
      step();
    end
    l2_ready = 1'b1; l2_hit = 1'b0; l2_valid = 1'b1; l2_rdata = c;
    #1;
    n_checks++;
    if (l2_read !== 1'b0) begin
      n_fail++; $display("FAIL miss_ready_cycle: l2_read %b required 0", l2_read);
    end
    step();
    l2_ready = 1'b0;
    n_checks++;
    if (req_ready !== 2'b01 || req_hit !== 1'b0 || req_rdata !== c) begin
      n_fail++; $display("FAIL miss_done: ready %b hit %b rdata %h required 01 0 %h",
                         req_ready, req_hit, req_rdata[63:0], c[63:0]);
    end
    step();
    step();
    n_checks++;
    if ({busy, l2_read, l2_write} !== 3'b000 || grant_cnt[0 +: CW] !== 3'd1) begin
      n_fail++; $display("FAIL miss_no_regrant: busy/rd/wr %b cnt0 %0d required 000 1",
                         {busy, l2_read, l2_write}, grant_cnt[0 +: CW]);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    req_read = 2'b01;
    for (int t = 1; t <= 9; t++) begin
      step();
      step();
      l2_ready = 1'b1;
      step();
      l2_ready = 1'b0;
      if (t == 1) begin
        n_checks++;
        if (req_ready !== 2'b01) begin
          n_fail++; $display("FAIL sat_ready: got %b required 01", req_ready);
        end
      end
      if (t == 7 || t == 9) begin
        n_checks++;
        if (grant_cnt[0 +: CW] !== 3'd7) begin
          n_fail++; $display("FAIL sat_cnt after %0d: got %0d required 7", t, grant_cnt[0 +: CW]);
        end
      end
      step();
    end
    req_read = 2'b00;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_addr[0 +: AW] = 11'h055;
    req_read = 2'b01;
    step();
    step();
    l2_ready = 1'b1; l2_rdata = pat(32'hDEAD_0000); l2_hit = 1'b1; l2_valid = 1'b1;
    step();
    l2_ready = 1'b0;
    step();
    step();
    n_checks++;
    if (busy !== 1'b1 || grant_cnt[0 +: CW] !== 3'd2 || req_hit !== 1'b1) begin
      n_fail++; $display("FAIL mid_setup: busy %b cnt0 %0d hit %b required 1 2 1", busy, grant_cnt[0 +: CW], req_hit);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, req_ready, l2_read, l2_write, req_hit, req_valid} !== '0 || grant_cnt !== '0) begin
      n_fail++; $display("FAIL mid_reset_ctrl: flags %b cnt %h required 0",
                         {busy, req_ready, l2_read, l2_write, req_hit, req_valid}, grant_cnt);
    end
    n_checks++;
    if (req_rdata !== '0 || l2_addr !== '0) begin
      n_fail++; $display("FAIL mid_reset_data: rdata %h addr %h required 0", req_rdata[63:0], l2_addr);
    end
    step();
    n_checks++;
    if (req_ready !== 2'b00) begin
      n_fail++; $display("FAIL mid_no_ready: got %b required 00", req_ready);
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if (busy !== 1'b1 || l2_read !== 1'b1 || l2_addr !== 11'h055 || grant_cnt[0 +: CW] !== 3'd1) begin
      n_fail++; $display("FAIL mid_regrant: busy %b rd %b addr %h cnt0 %0d required 1 1 055 1",
                         busy, l2_read, l2_addr, grant_cnt[0 +: CW]);
    end
    req_read = 2'b00;
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_round_robin();
    test_write_priority();
    test_read_miss();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
